// File: rtl/cbus_sram_responder.sv
// CBus SRAM responder: single-port 64-bit word store answering read/write bursts
// after a fixed latency. Optional macro CBUS_SRAM_BOUNDS_EN blocks out-of-range beats.
package cbus_common_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [3:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
endpackage

module cbus_sram_responder
    import cbus_common_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int LATENCY   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  ireq,
    output cbus_resp_t iresp
);
    localparam int IW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, BEAT} state_t;

    state_t      state;
    logic [28:0] wa;
    logic        is_wr;
    logic        incr_q;
    logic [3:0]  len_q;
    logic [3:0]  bcnt;
    logic [3:0]  dcnt;
    logic        ready_q;
    logic        last_q;
    logic [63:0] data_q;

    logic [63:0] mem [MEM_WORDS];

    logic [28:0] nxt_wa;
    logic [28:0] rd_wa;
    logic [63:0] rd_word;
    logic        rd_ok;
    logic        wr_ok;
    logic        wr_en;
    logic        unused_bits;

    assign nxt_wa = incr_q ? wa + 29'd1 : wa;

    // Word fetched for the beat that the next edge will present.
    always_comb begin
        rd_wa = wa;
        if (state == IDLE)
            rd_wa = ireq.addr[31:3];
        else if (state == BEAT)
            rd_wa = nxt_wa;
    end

`ifdef CBUS_SRAM_BOUNDS_EN
    assign rd_ok       = (rd_wa >> IW) == 29'd0;
    assign wr_ok       = (wa >> IW) == 29'd0;
    assign unused_bits = ^{ireq.size, ireq.addr[2:0]};
`else
    assign rd_ok       = 1'b1;
    assign wr_ok       = 1'b1;
    assign unused_bits = ^{ireq.size, ireq.addr[2:0], rd_wa[28:IW]};
`endif

    assign rd_word = rd_ok ? mem[rd_wa[IW-1:0]] : 64'd0;
    assign wr_en   = (state == BEAT) && is_wr && ireq.valid && wr_ok;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (ireq.strobe[i])
                    mem[wa[IW-1:0]][8*i +: 8] <= ireq.data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            wa      <= '0;
            is_wr   <= 1'b0;
            incr_q  <= 1'b0;
            len_q   <= '0;
            bcnt    <= '0;
            dcnt    <= '0;
            ready_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            ready_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            case (state)
                IDLE: begin
                    if (ireq.valid) begin
                        wa     <= ireq.addr[31:3];
                        is_wr  <= ireq.is_write;
                        len_q  <= ireq.len;
                        incr_q <= (ireq.burst == BURST_INCR);
                        bcnt   <= '0;
                        if (LATENCY == 0) begin
                            state   <= BEAT;
                            dcnt    <= '0;
                            ready_q <= 1'b1;
                            last_q  <= (ireq.len == 4'd0);
                            data_q  <= ireq.is_write ? 64'd0 : rd_word;
                        end else begin
                            state <= WAIT;
                            dcnt  <= 4'(LATENCY);
                        end
                    end
                end
                WAIT: begin
                    if (!ireq.valid) begin
                        state <= IDLE;
                        dcnt  <= '0;
                    end else if (dcnt == 4'd1) begin
                        state   <= BEAT;
                        dcnt    <= '0;
                        ready_q <= 1'b1;
                        last_q  <= (len_q == 4'd0);
                        data_q  <= is_wr ? 64'd0 : rd_word;
                    end else begin
                        dcnt <= dcnt - 4'd1;
                    end
                end
                BEAT: begin
                    // The ready cycle on screen ends here; either finish/abort or present the next beat.
                    if (!ireq.valid || (bcnt == len_q)) begin
                        state <= IDLE;
                        bcnt  <= '0;
                    end else begin
                        bcnt    <= bcnt + 4'd1;
                        wa      <= nxt_wa;
                        ready_q <= 1'b1;
                        last_q  <= ((bcnt + 4'd1) == len_q);
                        data_q  <= is_wr ? 64'd0 : rd_word;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign iresp = {ready_q, last_q, data_q};

endmodule

// File: tb/tb_cbus_sram_responder.sv
// Bench for cbus_sram_responder: table of bus transactions checked against a
// bench-side memory model via an expected-beat queue, plus abort/reset/back-to-back sequences.
module tb_cbus_sram_responder;
    import cbus_common_pkg::*;

    localparam int MW  = 4096;
    localparam int LAT = 2;

    logic       clk;
    logic       reset;
    cbus_req_t  ireq;
    cbus_resp_t iresp;

    cbus_sram_responder #(.MEM_WORDS(MW), .LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .ireq  (ireq),
        .iresp (iresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [1:0]  burst;
        logic [7:0]  strb;
        logic [63:0] base;
        logic        use_d0;
        logic [63:0] d0;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic        last;
        logic [63:0] data;
        logic        chk;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] model [MW];
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                                input logic [1:0] burst, input logic [7:0] strb, input logic [63:0] base,
                                input logic use_d0, input logic [63:0] d0);
        vec_t v;
        v.wr = wr; v.addr = addr; v.len = len; v.burst = burst; v.strb = strb;
        v.base = base; v.use_d0 = use_d0; v.d0 = d0; v.exp_lat = LAT + 1;
        return v;
    endfunction

    function automatic logic [31:0] beat_addr(input vec_t v, input int i);
        logic [31:0] a;
        a = {v.addr[31:3], 3'b000};
        if (v.burst == BURST_INCR)
            a = a + 32'(8 * i);
        return a;
    endfunction

    function automatic logic in_mem(input logic [31:0] ba);
`ifdef CBUS_SRAM_BOUNDS_EN
        return ba < 32'(MW * 8);
`else
        return ba == ba;
`endif
    endfunction

    function automatic int widx(input logic [31:0] ba);
        return int'((ba >> 3) & 32'(MW - 1));
    endfunction

    // Monitor: every ready beat must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && iresp.ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 64'(iresp.ready), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("beat_last", 64'(iresp.last), 64'(e.last));
                if (e.chk)
                    check("beat_data", iresp.data, e.data);
            end
        end
    end

    task automatic run_xact(input vec_t v, input int abort_at, output int nbeats, output int first_cyc);
        int   cyc;
        int   b;
        exp_t e;
        logic [31:0] ba;
        logic [63:0] w;
        @(negedge clk);
        ireq.valid    = 1'b1;
        ireq.is_write = v.wr;
        ireq.size     = 3'd3;
        ireq.addr     = v.addr;
        ireq.len      = v.len;
        ireq.burst    = v.burst;
        ireq.strobe   = v.strb;
        ireq.data     = v.base;
        for (int i = 0; i <= int'(v.len); i++) begin
            if (abort_at >= 0 && i > abort_at) break;
            ba     = beat_addr(v, i);
            e.last = (i == int'(v.len));
            e.chk  = !v.wr;
            e.data = in_mem(ba) ? model[widx(ba)] : 64'd0;
            if (i == 0 && v.use_d0) e.data = v.d0;
            exp_q.push_back(e);
            if (v.wr && (abort_at < 0 || i < abort_at) && in_mem(ba)) begin
                w = model[widx(ba)];
                for (int k = 0; k < 8; k++)
                    if (v.strb[k]) w[8*k +: 8] = v.base[8*k +: 8] + ((k == 0) ? 8'(i) : 8'd0);
                // carry of base+i beyond byte 0 is not used by the table
                model[widx(ba)] = w;
            end
        end
        b = 0; cyc = 0; first_cyc = -1;
        while (cyc < 80) begin
            @(posedge clk); #1;
            cyc++;
            if (iresp.ready) begin
                if (first_cyc < 0) first_cyc = cyc;
                ireq.data = v.base + 64'(b);
                if (b == abort_at) begin
                    ireq.valid = 1'b0;
                    b++;
                    break;
                end
                b++;
                if (iresp.last) begin
                    @(posedge clk); #1;
                    ireq.valid = 1'b0;
                    break;
                end
            end
        end
        if (cyc >= 80) begin
            check("xact_timeout", 64'(cyc), 64'd0);
            ireq.valid = 1'b0;
        end
        nbeats = b;
    endtask

    vec_t vt[18];

    initial begin
        int nb, fc, k, stray;
        int cs[2];
        logic [63:0] oob_exp;
        vec_t v;

        for (int i = 0; i < MW; i++) model[i] = 64'd0;
        ireq  = '0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(iresp.ready), 64'd0);
        check("rst_last",  64'(iresp.last),  64'd0);
        check("rst_data",  iresp.data,       64'd0);
        @(negedge clk);
        reset = 1'b1;

`ifdef CBUS_SRAM_BOUNDS_EN
        oob_exp = 64'd0;
`else
        oob_exp = 64'h5A5A;
`endif
        vt[0]  = mk(1, 32'h10,   4'd0,  BURST_INCR,  8'hFF, 64'hDEAD_BEEF_0000_0001, 0, 64'd0);
        vt[1]  = mk(0, 32'h10,   4'd0,  BURST_INCR,  8'hFF, 64'd0, 1, 64'hDEAD_BEEF_0000_0001);
        vt[2]  = mk(1, 32'h100,  4'd3,  BURST_INCR,  8'hFF, 64'd1, 0, 64'd0);
        vt[3]  = mk(0, 32'h100,  4'd3,  BURST_INCR,  8'hFF, 64'd0, 1, 64'd1);
        vt[4]  = mk(1, 32'h200,  4'd0,  BURST_INCR,  8'hFF, 64'hAAAA_AAAA_AAAA_AAAA, 0, 64'd0);
        vt[5]  = mk(1, 32'h200,  4'd0,  BURST_INCR,  8'h0F, 64'h1111_2222_3333_4444, 0, 64'd0);
        vt[6]  = mk(0, 32'h200,  4'd0,  BURST_INCR,  8'hFF, 64'd0, 1, 64'hAAAA_AAAA_3333_4444);
        vt[7]  = mk(1, 32'h8,    4'd0,  BURST_INCR,  8'hFF, 64'h77, 0, 64'd0);
        vt[8]  = mk(0, 32'h8,    4'd1,  BURST_FIXED, 8'hFF, 64'd0, 1, 64'h77);
        vt[9]  = mk(1, 32'h100,  4'd0,  BURST_INCR,  8'h00, 64'hFFFF, 0, 64'd0);
        vt[10] = mk(0, 32'h100,  4'd0,  BURST_INCR,  8'hFF, 64'd0, 1, 64'd1);
        vt[11] = mk(1, 32'h0,    4'd0,  BURST_INCR,  8'hFF, 64'h5A5A, 0, 64'd0);
        vt[12] = mk(0, 32'h8000, 4'd0,  BURST_INCR,  8'hFF, 64'd0, 1, oob_exp);
        vt[13] = mk(1, 32'h300,  4'd2,  BURST_FIXED, 8'hFF, 64'h30, 0, 64'd0);
        vt[14] = mk(0, 32'h300,  4'd0,  BURST_INCR,  8'hFF, 64'd0, 1, 64'h32);
        vt[15] = mk(1, 32'h400,  4'd15, BURST_INCR,  8'hFF, 64'h1000, 0, 64'd0);
        vt[16] = mk(0, 32'h400,  4'd15, BURST_INCR,  8'hFF, 64'd0, 1, 64'h1000);
        vt[17] = mk(1, 32'h500,  4'd3,  BURST_INCR,  8'hFF, 64'd0, 0, 64'd0);

        for (int i = 0; i < 18; i++) begin
            run_xact(vt[i], -1, nb, fc);
            check($sformatf("v%0d_latency", i), 64'(fc), 64'(vt[i].exp_lat));
            check($sformatf("v%0d_beats", i),   64'(nb), 64'(int'(vt[i].len) + 1));
        end

        // Abort a write burst during its third beat: beats 0 and 1 stay committed.
        v = mk(1, 32'h500, 4'd3, BURST_INCR, 8'hFF, 64'h10, 0, 64'd0);
        run_xact(v, 2, nb, fc);
        check("abort_beats", 64'(nb), 64'd3);
        stray = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (iresp.ready) stray++;
        end
        check("abort_no_ready", 64'(stray), 64'd0);
        v = mk(0, 32'h500, 4'd3, BURST_INCR, 8'hFF, 64'd0, 1, 64'h10);
        run_xact(v, -1, nb, fc);
        check("abort_rb_beats", 64'(nb), 64'd4);

        // Back-to-back: valid held high across two len=0 reads needs one IDLE cycle between.
        @(negedge clk);
        ireq.valid = 1'b1; ireq.is_write = 1'b0; ireq.addr = 32'h10;
        ireq.len = 4'd0; ireq.burst = BURST_INCR; ireq.strobe = 8'h00;
        for (int i = 0; i < 2; i++) exp_q.push_back('{last: 1'b1, data: 64'hDEAD_BEEF_0000_0001, chk: 1'b1});
        k = 0; cs[0] = 0; cs[1] = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (iresp.ready) begin
                cs[k] = c;
                k++;
                if (k == 2) begin
                    ireq.valid = 1'b0;
                    break;
                end
            end
        end
        check("b2b_count", 64'(k), 64'd2);
        check("b2b_gap", 64'(cs[1] - cs[0]), 64'(LAT + 2));
        @(posedge clk); #1;

        // Reset asserted during beat 2 of a len=7 read.
        @(negedge clk);
        ireq.valid = 1'b1; ireq.is_write = 1'b0; ireq.addr = 32'h400;
        ireq.len = 4'd7; ireq.burst = BURST_INCR;
        exp_q.push_back('{last: 1'b0, data: 64'h1000, chk: 1'b1});
        exp_q.push_back('{last: 1'b0, data: 64'h1001, chk: 1'b1});
        k = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (iresp.ready) k++;
            if (k == 2) break;
        end
        check("rstmid_seen", 64'(k), 64'd2);
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        check("rstmid_ready", 64'(iresp.ready), 64'd0);
        check("rstmid_last",  64'(iresp.last),  64'd0);
        check("rstmid_data",  iresp.data,       64'd0);
        ireq.valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        v = mk(0, 32'h10, 4'd0, BURST_INCR, 8'hFF, 64'd0, 1, 64'hDEAD_BEEF_0000_0001);
        run_xact(v, -1, nb, fc);
        check("post_rst_latency", 64'(fc), 64'(LAT + 1));
        check("post_rst_beats",   64'(nb), 64'd1);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cbus_sram_responder.md
CBUS_SRAM_RESPONDER -- requirements
Module: cbus_sram_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096, number of 64-bit words of backing storage (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, idle cycles between request acceptance and the first ready beat (0..15).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-low reset (reset==0 asserts).
REQ-005 SHALL have port ireq, input, cbus_req_t (common pkg), CBus request from the arbiter: valid, is_write, size, addr, strobe, data, len, burst.
REQ-006 SHALL have port iresp, output, cbus_resp_t (common pkg), CBus response: ready, last, data.

Function
REQ-007 SHALL implement states IDLE, WAIT, BEAT; reset enters IDLE.
REQ-008 IDLE: on ireq.valid, latch addr, is_write, len, burst; beat counter=0; delay counter=LATENCY; go to WAIT (BEAT directly if LATENCY==0).
REQ-009 WAIT: decrement delay counter each cycle; go to BEAT when it reaches 1.
REQ-010 BEAT: assert iresp.ready for exactly one cycle per beat; beat count = len+1 (len encodes beats-1, max 16).
REQ-011 iresp.last SHALL be 1 only in the ready cycle of the final beat (beat counter == latched len).
REQ-012 Read beat: iresp.data = mem[word index of current beat address], registered and valid in the same cycle as ready; 0 whenever ready==0.
REQ-013 Write beat: in the ready cycle, for each strobe bit i set, byte i of the word = ireq.data byte i; strobe==0 writes nothing.
REQ-014 Beat address: INCR adds 8 per beat from the 8-byte-aligned latched addr; FIXED reuses the latched addr every beat.
REQ-015 Word index = addr[3 +: log2(MEM_WORDS)]; higher bits ignored unless REQ-021 applies.
REQ-016 After the last beat SHALL return to IDLE and SHALL NOT accept a new request in that same cycle; back-to-back transactions need one IDLE cycle.
REQ-017 A drop of ireq.valid mid-transaction SHALL abort to IDLE with no further ready; writes already committed remain.
REQ-018 Request fields other than data/strobe SHALL be sampled only at acceptance; later changes are ignored.
REQ-019 Simultaneous read and write of one word cannot occur (single port, one beat per cycle); no forwarding needed.

Reset
REQ-020 While reset==0: state IDLE, counters 0, iresp.ready=0, iresp.last=0, iresp.data=0, asynchronously; memory contents are not cleared; a transaction in flight is discarded.

Configuration
REQ-021 Macro CBUS_SRAM_BOUNDS_EN: when defined, a beat whose byte address >= MEM_WORDS*8 reads 0 and discards writes, still handshaking with ready/last; when undefined, the address wraps modulo MEM_WORDS*8.

Verification
REQ-022 Single read, LATENCY=2: mem[2]=64'hDEAD_BEEF_0000_0001, req addr=0x10 len=0 -> ready&last in cycle 3 after acceptance, data=64'hDEAD_BEEF_0000_0001.
REQ-023 INCR write burst len=3 at 0x100, strobe 8'hFF, data 1,2,3,4 -> four ready pulses, last on the 4th; read-back burst returns 1,2,3,4.
REQ-024 Partial write strobe 8'h0F, data 64'h1111_2222_3333_4444 onto word 64'hAAAA_AAAA_AAAA_AAAA -> reads 64'hAAAA_AAAA_3333_4444.
REQ-025 FIXED read burst len=1 at 0x8 -> both beats return mem[1]; last only on the 2nd.
REQ-026 reset driven to 0 during beat 2 of a len=7 burst -> ready/last/data 0 immediately; after release, a new len=0 read completes normally.
REQ-027 Addr = MEM_WORDS*8 read: with CBUS_SRAM_BOUNDS_EN data=0; without it, data=mem[0].
